// File: rtl/store_commit_ctrl.sv
// Store commit gate: passes commits to the store buffer and holds them back while a fence drains it.
// Define STORE_COMMIT_WDOG_EN to build in the drain watchdog (wdog_err_o); otherwise it is tied to 0.
module store_commit_ctrl #(
  parameter int unsigned WDOG_CYCLES = 1024,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             commit_valid_i,
  output logic             commit_ready_o,
  input  logic             flush_i,
  input  logic             fence_req_i,
  output logic             fence_done_o,
  output logic             sb_commit_o,
  input  logic             sb_commit_ready_i,
  input  logic             sb_no_st_pending_i,
  input  logic             sb_empty_i,
  output logic [CNT_W-1:0] commit_cnt_o,
  output logic             wdog_err_o
);

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             commit_go;

  if (WDOG_CYCLES < 2) begin : g_bad_cfg
    $error("store_commit_ctrl: WDOG_CYCLES must be >= 2");
  end

  // A commit in the fence-request cycle is still issued, so it orders ahead of the fence.
  always_comb begin
    state_d   = state_q;
    commit_go = 1'b0;
    case (state_q)
      IDLE: begin
        commit_go = commit_valid_i & sb_commit_ready_i & ~flush_i;
        if (fence_req_i) state_d = DRAIN;
      end
      DRAIN:   if (sb_empty_i & sb_no_st_pending_i) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cnt_d = cnt_q + (commit_go ? CNT_W'(1) : CNT_W'(0));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sb_commit_o    = commit_go;
  assign commit_ready_o = commit_go;
  assign fence_done_o   = (state_q == DONE);
  assign commit_cnt_o   = cnt_q;

`ifdef STORE_COMMIT_WDOG_EN
  localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_CYCLES);

  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              err_q, err_d;

  // Counter only rises from a fresh clear on fence entry, so hitting the max marks a timeout.
  always_comb begin
    wdog_d = wdog_q;
    if (state_q == IDLE && state_d == DRAIN) wdog_d = '0;
    else if (state_q == DRAIN && wdog_q != WDOG_MAX) wdog_d = wdog_q + WDOG_W'(1);
    err_d = err_q | (wdog_d == WDOG_MAX);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign wdog_err_o = err_q;
`else
  assign wdog_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_store_commit_ctrl.sv
// Directed bench for store_commit_ctrl: commit gating, fence timing, watchdog, reset and counter wrap.
module tb_store_commit_ctrl;
  logic       clk_i = 1'b0;
  logic       rst_ni, commit_valid_i, flush_i, fence_req_i;
  logic       sb_commit_ready_i, sb_no_st_pending_i, sb_empty_i;
  logic       commit_ready_o, fence_done_o, sb_commit_o, wdog_err_o;
  logic [3:0] commit_cnt_o;
  int tests = 0, fails = 0;

`ifdef STORE_COMMIT_WDOG_EN
  localparam logic EXP_WDOG = 1'b1;
`else
  localparam logic EXP_WDOG = 1'b0;
`endif

  store_commit_ctrl #(.WDOG_CYCLES(8), .CNT_W(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .commit_valid_i(commit_valid_i),
    .commit_ready_o(commit_ready_o), .flush_i(flush_i), .fence_req_i(fence_req_i),
    .fence_done_o(fence_done_o), .sb_commit_o(sb_commit_o),
    .sb_commit_ready_i(sb_commit_ready_i), .sb_no_st_pending_i(sb_no_st_pending_i),
    .sb_empty_i(sb_empty_i), .commit_cnt_o(commit_cnt_o), .wdog_err_o(wdog_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_ni = 1'b0; commit_valid_i = 1'b0; flush_i = 1'b0; fence_req_i = 1'b0;
    sb_commit_ready_i = 1'b0; sb_no_st_pending_i = 1'b1; sb_empty_i = 1'b1;
    step(); step();
    chk("rst_fence_done", 32'(fence_done_o), 0);
    chk("rst_cnt", 32'(commit_cnt_o), 0);
    chk("rst_wdog", 32'(wdog_err_o), 0);
    rst_ni = 1'b1;
    step();

    // back-to-back commits
    commit_valid_i = 1'b1; sb_commit_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("b2b_sb_commit", 32'(sb_commit_o), 1);
      chk("b2b_ready", 32'(commit_ready_o), 1);
      step();
    end
    commit_valid_i = 1'b0; #1;
    chk("b2b_cnt", 32'(commit_cnt_o), 4);

    // backpressure and flush
    commit_valid_i = 1'b1; sb_commit_ready_i = 1'b0; #1;
    chk("bp_ready", 32'(commit_ready_o), 0);
    chk("bp_sb_commit", 32'(sb_commit_o), 0);
    step();
    sb_commit_ready_i = 1'b1; flush_i = 1'b1; #1;
    chk("flush_ready", 32'(commit_ready_o), 0);
    step();
    chk("flush_cnt", 32'(commit_cnt_o), 4);
    flush_i = 1'b0; commit_valid_i = 1'b0;

    // fence with empty buffer: done two cycles after request
    fence_req_i = 1'b1; #1;
    chk("fe_done_n0", 32'(fence_done_o), 0);
    step();
    fence_req_i = 1'b0; commit_valid_i = 1'b1; #1;
    chk("fe_done_n1", 32'(fence_done_o), 0);
    chk("fe_drain_ready", 32'(commit_ready_o), 0);
    step();
    chk("fe_done_n2", 32'(fence_done_o), 1);
    chk("fe_done_ready", 32'(commit_ready_o), 0);
    step();
    chk("fe_done_n3", 32'(fence_done_o), 0);
    chk("fe_idle_ready", 32'(commit_ready_o), 1);
    step();
    commit_valid_i = 1'b0; #1;
    chk("fe_cnt", 32'(commit_cnt_o), 5);

    // fence with pending stores; cycle 5 = request cycle
    sb_no_st_pending_i = 1'b0;
    fence_req_i = 1'b1; commit_valid_i = 1'b1; #1;
    chk("fp_c5_commit", 32'(sb_commit_o), 1);
    step();
    fence_req_i = 1'b0;
    for (int c = 6; c <= 20; c++) begin
      if (c == 10) fence_req_i = 1'b1;
      if (c == 11) fence_req_i = 1'b0;
      flush_i = (c == 12);
      if (c == 20) sb_no_st_pending_i = 1'b1;
      #1;
      chk("fp_drain_ready", 32'(commit_ready_o), 0);
      chk("fp_drain_done", 32'(fence_done_o), 0);
      step();
    end
    flush_i = 1'b0; #1;
    chk("fp_c21_done", 32'(fence_done_o), 1);
    chk("fp_c21_ready", 32'(commit_ready_o), 0);
    chk("fp_c21_cnt", 32'(commit_cnt_o), 6);
    step();
    chk("fp_c22_ready", 32'(commit_ready_o), 1);
    step();
    commit_valid_i = 1'b0; #1;
    chk("fp_cnt", 32'(commit_cnt_o), 7);
    chk("fp_no_requeue", 32'(fence_done_o), 0);

    // watchdog: hold DRAIN with a non-empty buffer
    sb_empty_i = 1'b0;
    fence_req_i = 1'b1; step();
    fence_req_i = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      chk("wd_before", 32'(wdog_err_o), 0);
      step();
    end
    chk("wd_rise", 32'(wdog_err_o), 32'(EXP_WDOG));
    chk("wd_still_drain", 32'(fence_done_o), 0);
    sb_empty_i = 1'b1; step();
    chk("wd_done", 32'(fence_done_o), 1);
    chk("wd_sticky_done", 32'(wdog_err_o), 32'(EXP_WDOG));
    step();
    chk("wd_sticky_idle", 32'(wdog_err_o), 32'(EXP_WDOG));

    // reset mid-fence
    sb_empty_i = 1'b0;
    fence_req_i = 1'b1; step();
    fence_req_i = 1'b0; #1;
    chk("rm_in_drain", 32'(commit_ready_o), 0);
    rst_ni = 1'b0; step();
    rst_ni = 1'b1; sb_empty_i = 1'b1; #1;
    chk("rm_done", 32'(fence_done_o), 0);
    chk("rm_cnt", 32'(commit_cnt_o), 0);
    chk("rm_wdog", 32'(wdog_err_o), 0);
    commit_valid_i = 1'b1; #1;
    chk("rm_idle_ready", 32'(commit_ready_o), 1);
    commit_valid_i = 1'b0;
    step();
    chk("rm_done_n1", 32'(fence_done_o), 0);
    step();
    chk("rm_done_n2", 32'(fence_done_o), 0);
    chk("rm_cnt_hold", 32'(commit_cnt_o), 0);

    // counter wrap with 4-bit counter
    commit_valid_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      step();
      if (i == 14) chk("wrap_15", 32'(commit_cnt_o), 15);
      if (i == 15) chk("wrap_0", 32'(commit_cnt_o), 0);
    end
    commit_valid_i = 1'b0; #1;
    chk("wrap_17", 32'(commit_cnt_o), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/store_commit_ctrl.md
STORE_COMMIT_CTRL -- requirements
Module: store_commit_ctrl

Interface
REQ-001 SHALL have parameter WDOG_CYCLES, default 1024: fence-drain watchdog limit in cycles (>=2).
REQ-002 SHALL have parameter CNT_W, default 32: width of the commit statistics counter.
REQ-003 SHALL have one clock; reset is synchronous and active-low (ports clk_i, rst_ni).
REQ-004 clk_i  in  1  clock; all state updates on the rising edge.
REQ-005 rst_ni  in  1  synchronous active-low reset.
REQ-006 commit_valid_i  in  1  commit stage requests commit of the oldest speculative store.
REQ-007 commit_ready_o  out  1  commit accepted this cycle.
REQ-008 flush_i  in  1  pipeline flush.
REQ-009 fence_req_i  in  1  single-cycle fence request pulse.
REQ-010 fence_done_o  out  1  single-cycle fence-complete pulse.
REQ-011 sb_commit_o  out  1  drives the store buffer commit_i.
REQ-012 sb_commit_ready_i  in  1  from store buffer commit_ready_o.
REQ-013 sb_no_st_pending_i  in  1  from store buffer no_st_pending_o.
REQ-014 sb_empty_i  in  1  from store buffer store_buffer_empty_o.
REQ-015 commit_cnt_o  out  CNT_W  total stores committed, modulo 2^CNT_W.
REQ-016 wdog_err_o  out  1  sticky drain-timeout flag.

Function
REQ-017 FSM states SHALL be IDLE, DRAIN, DONE; encoding is free.
REQ-018 In IDLE, sb_commit_o and commit_ready_o SHALL both equal commit_valid_i & sb_commit_ready_i & ~flush_i, combinationally, with zero latency.
REQ-019 In DRAIN and DONE, sb_commit_o and commit_ready_o SHALL be 0: no commits pass a pending fence.
REQ-020 IDLE->DRAIN SHALL occur on the clock edge where fence_req_i=1. A commit accepted in that same cycle SHALL be issued normally, so it is ordered ahead of the fence.
REQ-021 fence_req_i SHALL be ignored in DRAIN and DONE; no queuing.
REQ-022 DRAIN->DONE SHALL occur on the edge where sb_empty_i & sb_no_st_pending_i = 1; otherwise the FSM SHALL remain in DRAIN.
REQ-023 DONE->IDLE SHALL occur unconditionally after one cycle.
REQ-024 fence_done_o SHALL be 1 exactly while in DONE, a one-cycle registered pulse.
REQ-025 Fence latency with an already-empty buffer SHALL be: fence_req_i in cycle N, fence_done_o in cycle N+2.
REQ-026 flush_i SHALL NOT change FSM state; a fence in progress still completes.
REQ-027 commit_cnt_o SHALL increment by 1 on every edge where sb_commit_o=1, wrapping from 2^CNT_W-1 to 0 with no flag.

Reset
REQ-028 While rst_ni=0 at a rising edge: FSM SHALL go to IDLE, commit_cnt_o to 0, the watchdog counter to 0, and wdog_err_o to 0.
REQ-029 Reset during DRAIN or DONE SHALL abandon the fence without asserting fence_done_o.
REQ-030 Reset value of fence_done_o SHALL be 0. sb_commit_o and commit_ready_o SHALL follow REQ-018 from the cycle after reset.

Configuration
REQ-031 Macro STORE_COMMIT_WDOG_EN SHALL compile the drain watchdog in or out.
REQ-032 With STORE_COMMIT_WDOG_EN defined, the watchdog SHALL behave as follows:
- a $clog2(WDOG_CYCLES+1)-bit counter clears on IDLE->DRAIN;
- it increments each cycle spent in DRAIN and saturates at WDOG_CYCLES;
- wdog_err_o sets on the edge where the counter reaches WDOG_CYCLES and stays set until reset;
- the FSM is unaffected.
REQ-033 Without STORE_COMMIT_WDOG_EN, wdog_err_o SHALL be constant 0 and no watchdog counter SHALL exist.

Verification
REQ-034 Back-to-back commits: IDLE, commit_valid_i=1 and sb_commit_ready_i=1 for 4 cycles -> sb_commit_o=1 on all 4 cycles, commit_cnt_o=4.
REQ-035 Backpressure and flush: sb_commit_ready_i=0 with commit_valid_i=1 -> commit_ready_o=0. flush_i=1 with ready=1 -> commit_ready_o=0; commit_cnt_o unchanged.
REQ-036 Fence while empty: fence_req_i pulse at cycle 10, sb_empty_i=sb_no_st_pending_i=1 -> DRAIN in cycle 11, fence_done_o=1 only in cycle 12.
REQ-037 Fence with pending stores:
- stimulus: fence_req_i and commit_valid_i both 1 in cycle 5; sb_no_st_pending_i falls to 0 and rises in cycle 20;
- response: commit issued in cycle 5; commit_ready_o=0 in cycles 6-21; fence_done_o in cycle 21.
REQ-038 Watchdog (macro defined, WDOG_CYCLES=8): hold DRAIN with sb_empty_i=0 -> wdog_err_o rises after 8 DRAIN cycles and stays 1 after the drain completes. Macro undefined -> wdog_err_o stays 0.
REQ-039 Reset mid-fence: rst_ni=0 for 1 cycle while in DRAIN -> IDLE next cycle, fence_done_o never asserts, commit_cnt_o=0.
REQ-040 Counter wrap: CNT_W=4, 17 commits -> commit_cnt_o=1.
